// File: rtl/c4_pkg.sv
// Shared types and constants for the Connect Four move sequencer.
package c4_pkg;

  typedef enum logic [1:0] {IDLE, DROP, LAND, FULL} state_t;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    RED    = 2'd1,
    YELLOW = 2'd2
  } cell_t;

  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT = 8'h07;
  localparam logic [7:0] KEY_DROP  = 8'h2C;

  localparam int unsigned COLS  = 7;
  localparam int unsigned ROWS  = 6;
  localparam int unsigned CELLS = COLS * ROWS;

  function automatic cell_t player_cell(input logic p);
    return p ? YELLOW : RED;
  endfunction

endpackage

// File: rtl/c4_board.sv
// 7x6 board storage with per-column fill heights and a move counter.
module c4_board
  import c4_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       we,
  input  logic [2:0] wr_col,
  input  logic [1:0] wr_val,
  input  logic [2:0] rd_col,
  input  logic [2:0] rd_row,
  output logic [1:0] rd_cell,
  input  logic [2:0] sel_col,
  output logic [2:0] sel_height,
  output logic [5:0] move_count,
  output logic       full
);

  cell_t      cells  [COLS][ROWS];
  logic [2:0] height [COLS];
  logic [2:0] wr_row;

  // Tokens stack from the bottom row (ROWS-1) upward.
  assign wr_row = 3'(ROWS - 1) - height[wr_col];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < COLS; c++) begin
        height[c] <= '0;
        for (int unsigned r = 0; r < ROWS; r++) cells[c][r] <= EMPTY;
      end
      move_count <= '0;
    end else if (clr) begin
      for (int unsigned c = 0; c < COLS; c++) begin
        height[c] <= '0;
        for (int unsigned r = 0; r < ROWS; r++) cells[c][r] <= EMPTY;
      end
      move_count <= '0;
    end else if (we && wr_col < 3'(COLS) && height[wr_col] < 3'(ROWS)) begin
      cells[wr_col][wr_row] <= cell_t'(wr_val);
      height[wr_col]        <= height[wr_col] + 3'd1;
      move_count            <= move_count + 6'd1;
    end
  end

  always_comb begin
    rd_cell = '0;
    if (rd_col < 3'(COLS) && rd_row < 3'(ROWS)) rd_cell = cells[rd_col][rd_row];
  end

  assign sel_height = (sel_col < 3'(COLS)) ? height[sel_col] : 3'(ROWS);
  assign full       = (move_count == 6'(CELLS));

endmodule

// File: rtl/drop_controller.sv
// Connect Four move sequencer: key decode, cursor, falling-token animation, board commit.
module drop_controller
  import c4_pkg::*;
#(
  parameter int unsigned X_ORIGIN  = 50,
  parameter int unsigned Y_TOP     = 150,
  parameter int unsigned CELL      = 40,
  parameter int unsigned DROP_STEP = 4
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_tick,
  input  logic       new_game,
  input  logic [7:0] keycode,
  output logic [9:0] BallX,
  output logic [9:0] BallY,
  output logic       player,
  output logic [2:0] cursor_col,
  output logic       busy,
  output logic       board_full,
  input  logic [2:0] rd_col,
  input  logic [2:0] rd_row,
  output logic [1:0] rd_cell
);

  localparam logic [9:0]  X_ORIGIN_W = 10'(X_ORIGIN);
  localparam logic [9:0]  Y_TOP_W    = 10'(Y_TOP);
  localparam logic [9:0]  CELL_W     = 10'(CELL);
  localparam logic [10:0] STEP_W     = 11'(DROP_STEP);

  state_t     state, state_n;
  logic [7:0] prev_key;
  logic [2:0] cur, cur_n;
  logic [2:0] trow, trow_n;
  logic [9:0] ball_y, ball_y_n;
  logic       ply, ply_n;

  logic       key_evt;
  logic [9:0] target_y;
  logic [10:0] step_y;

  logic       board_we, board_clr;
  logic [1:0] wr_val;
  logic [2:0] sel_height;
  logic [5:0] move_count;
  logic       full;

  assign key_evt  = (keycode != 8'h00) && (keycode != prev_key);
  assign target_y = Y_TOP_W + CELL_W * {7'b0, trow + 3'd1};
  // One extra bit so a large step past target_y cannot wrap and miss the landing.
  assign step_y   = {1'b0, ball_y} + STEP_W;
  assign wr_val   = player_cell(ply);

  c4_board u_board (
    .clk        (Clk),
    .rst_n      (Reset_n),
    .clr        (board_clr),
    .we         (board_we),
    .wr_col     (cur),
    .wr_val     (wr_val),
    .rd_col     (rd_col),
    .rd_row     (rd_row),
    .rd_cell    (rd_cell),
    .sel_col    (cur),
    .sel_height (sel_height),
    .move_count (move_count),
    .full       (full)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      prev_key <= '0;
      cur      <= 3'd3;
      trow     <= '0;
      ball_y   <= Y_TOP_W;
      ply      <= 1'b0;
    end else begin
      state    <= state_n;
      prev_key <= keycode;
      cur      <= cur_n;
      trow     <= trow_n;
      ball_y   <= ball_y_n;
      ply      <= ply_n;
    end
  end

  always_comb begin
    state_n   = state;
    cur_n     = cur;
    trow_n    = trow;
    ball_y_n  = ball_y;
    ply_n     = ply;
    board_we  = 1'b0;
    board_clr = 1'b0;

    case (state)
      IDLE: begin
        if (full) begin
          state_n = FULL;
        end else if (key_evt) begin
          if (keycode == KEY_LEFT && cur != 3'd0) begin
            cur_n = cur - 3'd1;
          end else if (keycode == KEY_RIGHT && cur != 3'(COLS - 1)) begin
            cur_n = cur + 3'd1;
          end else if (keycode == KEY_DROP && sel_height < 3'(ROWS)) begin
            trow_n  = 3'(ROWS - 1) - sel_height;
            state_n = DROP;
          end
        end
      end
      DROP: begin
        if (frame_tick) begin
          if (step_y >= {1'b0, target_y}) begin
            ball_y_n = target_y;
            state_n  = LAND;
          end else begin
            ball_y_n = step_y[9:0];
          end
        end
      end
      LAND: begin
        board_we = 1'b1;
        ply_n    = ~ply;
        ball_y_n = Y_TOP_W;
        // The counter increments at this edge, so test against the pre-write value.
        state_n  = (move_count == 6'(CELLS - 1)) ? FULL : IDLE;
      end
      FULL: ;
      default: state_n = IDLE;
    endcase

    if (new_game) begin
      board_clr = 1'b1;
      board_we  = 1'b0;
      ply_n     = 1'b0;
      cur_n     = 3'd3;
      ball_y_n  = Y_TOP_W;
      state_n   = IDLE;
    end
  end

  assign BallX      = X_ORIGIN_W + CELL_W * {7'b0, cur};
  assign BallY      = ball_y;
  assign player     = ply;
  assign cursor_col = cur;
  assign busy       = (state == DROP) || (state == LAND);
  assign board_full = (state == FULL);

endmodule

// File: tb/tb_drop_controller.sv
// Scoreboard bench for drop_controller: expectations queued at stimulus time, checked on output.
module tb_drop_controller;

  localparam int unsigned XO = 50;
  localparam int unsigned YT = 150;
  localparam int unsigned CL = 40;
  localparam int unsigned ST = 4;

  localparam int SEL_CUR  = 0;
  localparam int SEL_BX   = 1;
  localparam int SEL_BY   = 2;
  localparam int SEL_PLY  = 3;
  localparam int SEL_BUSY = 4;
  localparam int SEL_FULL = 5;
  localparam int SEL_CELL = 6;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       new_game = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic [2:0] rd_col = 3'd0;
  logic [2:0] rd_row = 3'd0;
  logic [9:0] BallX, BallY;
  logic       player, busy, board_full;
  logic [2:0] cursor_col;
  logic [1:0] rd_cell;

  drop_controller #(
    .X_ORIGIN  (XO),
    .Y_TOP     (YT),
    .CELL      (CL),
    .DROP_STEP (ST)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .frame_tick (frame_tick),
    .new_game   (new_game),
    .keycode    (keycode),
    .BallX      (BallX),
    .BallY      (BallY),
    .player     (player),
    .cursor_col (cursor_col),
    .busy       (busy),
    .board_full (board_full),
    .rd_col     (rd_col),
    .rd_row     (rd_row),
    .rd_cell    (rd_cell)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string       tag;
    int          sel;
    int unsigned col;
    int unsigned row;
    int unsigned val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  int unsigned m_cur, m_player, m_moves;
  int unsigned m_h[7];
  int unsigned m_cell[7][6];

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic expect_sig(input string tag, input int sel, input int unsigned val);
    exp_t e;
    e.tag = tag; e.sel = sel; e.col = 0; e.row = 0; e.val = val;
    sb.push_back(e);
  endtask

  task automatic expect_cell(input string tag, input int unsigned col, input int unsigned row,
                             input int unsigned val);
    exp_t e;
    e.tag = tag; e.sel = SEL_CELL; e.col = col; e.row = row; e.val = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    int unsigned got;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      got = 0;
      case (e.sel)
        SEL_CUR:  got = int'(cursor_col);
        SEL_BX:   got = int'(BallX);
        SEL_BY:   got = int'(BallY);
        SEL_PLY:  got = int'(player);
        SEL_BUSY: got = int'(busy);
        SEL_FULL: got = int'(board_full);
        default: begin
          rd_col = 3'(e.col);
          rd_row = 3'(e.row);
          #1;
          got = int'(rd_cell);
        end
      endcase
      check(e.tag, got, e.val);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic model_clear();
    m_cur = 3; m_player = 0; m_moves = 0;
    for (int c = 0; c < 7; c++) begin
      m_h[c] = 0;
      for (int r = 0; r < 6; r++) m_cell[c][r] = 0;
    end
  endtask

  task automatic press(input logic [7:0] k);
    keycode = k;
    step();
    keycode = 8'h00;
    step();
  endtask

  task automatic pulse_new_game();
    new_game = 1'b1;
    step();
    new_game = 1'b0;
    model_clear();
  endtask

  task automatic move_to(input int unsigned col);
    while (m_cur < col) begin press(8'h07); m_cur++; end
    while (m_cur > col) begin press(8'h04); m_cur--; end
  endtask

  task automatic drop_at(input int unsigned col, input bit detail);
    int unsigned row, frames, n, ty;
    move_to(col);
    row    = 5 - m_h[col];
    frames = (CL * (row + 1) + ST - 1) / ST;
    ty     = YT + CL * (row + 1);
    keycode = 8'h2C;
    step();
    keycode = 8'h00;
    expect_sig("busy_after_drop", SEL_BUSY, 1);
    drain();
    n = 0;
    while (int'(BallY) != ty && n < 400) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      n++;
    end
    check("land_frames", n, frames);
    if (detail) begin
      expect_sig("land_bally", SEL_BY, ty);
      expect_sig("land_busy", SEL_BUSY, 1);
      drain();
    end
    step();
    m_cell[col][row] = m_player + 1;
    m_h[col]++;
    m_moves++;
    m_player ^= 1;
    expect_sig("post_land_busy", SEL_BUSY, 0);
    expect_sig("post_land_player", SEL_PLY, m_player);
    expect_sig("post_land_bally", SEL_BY, YT);
    expect_sig("post_land_full", SEL_FULL, (m_moves == 42) ? 1 : 0);
    expect_cell("landed_cell", col, row, m_cell[col][row]);
    drain();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int unsigned n;
    int unsigned cols[6];
    model_clear();

    #12;
    expect_sig("rst_cursor", SEL_CUR, 3);
    expect_sig("rst_ballx", SEL_BX, XO + 3 * CL);
    expect_sig("rst_bally", SEL_BY, YT);
    expect_sig("rst_player", SEL_PLY, 0);
    expect_sig("rst_busy", SEL_BUSY, 0);
    expect_sig("rst_full", SEL_FULL, 0);
    expect_cell("rst_cell05", 0, 5, 0);
    expect_cell("oob_col", 7, 0, 0);
    drain();
    @(negedge Clk);
    Reset_n = 1'b1;
    step();

    // held right key fires once; re-press fires again
    keycode = 8'h07;
    step();
    expect_sig("right_first", SEL_CUR, 4);
    drain();
    repeat (9) step();
    expect_sig("right_held", SEL_CUR, 4);
    drain();
    keycode = 8'h00;
    step();
    keycode = 8'h07;
    step();
    keycode = 8'h00;
    step();
    m_cur = 5;
    expect_sig("right_again", SEL_CUR, 5);
    expect_sig("right_ballx", SEL_BX, XO + 5 * CL);
    drain();

    pulse_new_game();
    expect_sig("ng_cursor", SEL_CUR, 3);
    drain();
    repeat (5) press(8'h04);
    m_cur = 0;
    expect_sig("left_sat", SEL_CUR, 0);
    expect_sig("left_ballx", SEL_BX, XO);
    drain();

    drop_at(0, 1'b1);

    // fill column 2, then a refused drop must not count as a move
    pulse_new_game();
    repeat (6) drop_at(2, 1'b0);
    keycode = 8'h2C;
    step();
    keycode = 8'h00;
    expect_sig("fullcol_busy", SEL_BUSY, 0);
    expect_sig("fullcol_cursor", SEL_CUR, 2);
    expect_sig("fullcol_player", SEL_PLY, m_player);
    drain();
    step();
    expect_sig("fullcol_busy2", SEL_BUSY, 0);
    expect_cell("fullcol_top", 2, 0, m_cell[2][0]);
    drain();

    cols = '{0, 1, 3, 4, 5, 6};
    foreach (cols[i]) repeat (6) drop_at(cols[i], 1'b0);
    press(8'h04);
    press(8'h2C);
    expect_sig("full_keys_cursor", SEL_CUR, m_cur);
    expect_sig("full_keys_busy", SEL_BUSY, 0);
    expect_sig("full_stays", SEL_FULL, 1);
    drain();
    for (int c = 0; c < 7; c++)
      for (int r = 0; r < 6; r++)
        expect_cell("full_board", c, r, m_cell[c][r]);
    drain();

    pulse_new_game();
    for (int c = 0; c < 7; c++)
      for (int r = 0; r < 6; r++)
        expect_cell("cleared", c, r, 0);
    expect_sig("ng_player", SEL_PLY, 0);
    expect_sig("ng_cursor2", SEL_CUR, 3);
    expect_sig("ng_full", SEL_FULL, 0);
    drain();

    // reset while the token is falling
    keycode = 8'h2C;
    step();
    keycode = 8'h00;
    n = 0;
    while (BallY < 10'd200 && n < 100) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      n++;
    end
    expect_sig("mid_bally", SEL_BY, YT + ST * ((200 - YT + ST - 1) / ST));
    expect_sig("mid_busy", SEL_BUSY, 1);
    drain();
    Reset_n = 1'b0;
    #1;
    expect_sig("rst_mid_busy", SEL_BUSY, 0);
    expect_sig("rst_mid_bally", SEL_BY, YT);
    expect_sig("rst_mid_cursor", SEL_CUR, 3);
    expect_sig("rst_mid_ballx", SEL_BX, XO + 3 * CL);
    expect_sig("rst_mid_player", SEL_PLY, 0);
    drain();
    @(negedge Clk);
    Reset_n = 1'b1;
    step();
    expect_cell("rst_mid_nowrite", 3, 5, 0);
    expect_sig("rst_mid_busy2", SEL_BUSY, 0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/drop_controller.md
# drop_controller

Sequences one Connect Four move at a time. It turns keyboard keycodes into cursor moves and drops, animates the falling token one frame at a time, and commits the token to an internal 7×6 board. It alternates players and detects a full board. Its BallX/BallY outputs drive the token sprite position consumed by the color mapper; its board read port feeds the board renderer.

## Interface
Parameters:
- X_ORIGIN, 50: pixel X of column 0 token.
- Y_TOP, 150: pixel Y of the hover (aim) row.
- CELL, 40: pixel pitch between columns and between rows.
- DROP_STEP, 4: pixels fallen per frame tick.

Ports:
- Clk  in  1  system clock; all state on its rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-Clk pulse per video frame, synchronous to Clk.
- new_game  in  1  one-Clk pulse; clears board, returns to IDLE.
- keycode  in  8  current USB HID keycode, 0x00 = none.
- BallX  out  10  token sprite X.
- BallY  out  10  token sprite Y.
- player  out  1  side to move (0 = red, 1 = yellow).
- cursor_col  out  3  aimed column, 0..6.
- busy  out  1  high in DROP and LAND.
- board_full  out  1  high in FULL.
- rd_col  in  3  board read column.
- rd_row  in  3  board read row, 0 = top.
- rd_cell  out  2  combinational cell contents: 0 empty, 1 red, 2 yellow; 0 for out-of-range row/col.

## Operation
- Key events: keycode registered each Clk (prev_key). An event fires when keycode ≠ 0 and keycode ≠ prev_key. Held keys fire once.
- Keys: 0x04 (A) = left, 0x07 (D) = right, 0x2C (space) = drop. All other codes are ignored.
- States: IDLE, DROP, LAND, FULL.
- IDLE:
  - left: cursor_col decrements, saturating at 0.
  - right: cursor_col increments, saturating at 6.
  - drop: accepted only if height[cursor_col] < 6. On accept, latch target_row = 5 − height[cursor_col] and go to DROP. A drop on a full column is ignored.
- DROP:
  - On each frame_tick, BallY = min(BallY + DROP_STEP, target_y), where target_y = Y_TOP + CELL·(target_row+1).
  - When BallY == target_y, go to LAND.
  - Key events in DROP are discarded.
- LAND: one cycle.
  - Write cell(cursor_col, target_row) = player+1; height[cursor_col]++; move_count++.
  - Toggle player; BallY = Y_TOP.
  - Next state is FULL if move_count reaches 42, else IDLE.
- FULL: ignores keys; exits only on new_game or reset.
- new_game: honoured in any state.
  - Clears board, heights and move_count.
  - player = 0, cursor_col = 3, BallY = Y_TOP, state IDLE.
  - An in-flight token is discarded.
- BallX = X_ORIGIN + CELL·cursor_col. Combinational, 10 bits.
- Width rules:
  - Arithmetic is 10 bits unsigned.
  - Parameters must satisfy Y_TOP + 7·CELL < 1024 and X_ORIGIN + 6·CELL < 1024.
  - Saturation guarantees landing when CELL is not a multiple of DROP_STEP.

## Timing
- Reset (async assert, sync deassert via Clk): state IDLE, board empty, heights 0, move_count 0, player 0, cursor_col 3, BallX = X_ORIGIN+3·CELL, BallY = Y_TOP, busy 0, board_full 0, prev_key 0.
- Key event latency: keycode change at edge N, event detected at edge N+1, cursor_col/state updated at edge N+1 (visible after it).
- A drop accepted at edge N gives busy = 1 after N. The first BallY step occurs on the first frame_tick after N.
- Frames to land = ceil(CELL·(target_row+1)/DROP_STEP). LAND follows the tick that reaches target_y, and the board write is visible on rd_cell one cycle later.
- frame_tick coinciding with a key event in IDLE: the key is processed and the tick has no effect.
- new_game coinciding with any event: new_game wins.
- Reset mid-DROP: all state returns to reset values; no board write.

## Structure
- Package c4_pkg:
  - state_t enum (IDLE, DROP, LAND, FULL).
  - cell_t enum (EMPTY=0, RED=1, YELLOW=2).
  - Keycode constants KEY_LEFT, KEY_RIGHT, KEY_DROP.
  - COLS = 7, ROWS = 6.
- Sub-module c4_board:
  - Holds 7×6 cell_t array, per-column 3-bit heights, move counter.
  - Ports: write enable/column/value, clear, combinational read port, height of a selected column, full flag.
- drop_controller holds the FSM, key edge detect, cursor and animation counters.

## Test plan
- Reset, then keycode 0x07 held 10 cycles then 0x00, then 0x07 again: cursor_col 3→4→5. BallX = 50+5·40 = 250.
- Keycode 0x04 pressed 5 times from column 3: cursor_col saturates at 0, BallX = 50.
- Drop in empty column 0 with DROP_STEP 4: busy for 60 ticks, BallY reaches 390. Then rd_cell(0,5) = 1, player = 1, BallY = 150.
- Fill column 2 with 6 drops, then press space on column 2: no state change, busy stays 0, move_count unchanged.
- 42 legal drops alternating players: board_full = 1 after the last LAND, and keys are ignored. new_game returns all cells to 0, player 0, cursor_col 3.
- Assert Reset_n low during DROP at BallY = 200: outputs immediately at reset values, and no cell is written.
